demux_1_8_tdm_ctrl: RTL and testbench

//  Frame-sync controller and sequencer for the 1:8 demultiplexer path.

---
 rtl/demux_1_8_tdm_ctrl.sv | 141 ++++++++++++++
 tb/tb_demux_1_8_tdm_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_8_tdm_ctrl.sv
// rtl/demux_1_8_tdm_ctrl.sv - frame-sync hunter and channel sequencer for the 1:8 TDM demux
module demux_1_8_tdm_ctrl #(
    parameter int                  SYNC_LEN = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT = 8'hA5,
    parameter int                  CH_W     = 4,
    parameter int                  MISS_MAX = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            din,
    input  logic            din_valid,
    output logic [2:0]      sel,
    output logic [CH_W-1:0] ch_data,
    output logic [7:0]      ch_strobe,
    output logic            locked,
    output logic            sync_err
);

    localparam int CNT_MAX = (SYNC_LEN > CH_W) ? SYNC_LEN : CH_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int MISS_W  = $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SYNC_LEN-1:0] sr_q, sr_d, sr_shift;
    logic [CH_W-1:0]     ch_sr_q, ch_sr_d, word;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]          ch_q, ch_d;
    logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
    logic [CH_W-1:0]     ch_data_q, ch_data_d;
    logic [7:0]          strobe_q, strobe_d;
    logic                err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            sr_q      <= '0;
            ch_sr_q   <= '0;
            bit_cnt_q <= '0;
            ch_q      <= '0;
            miss_q    <= '0;
            ch_data_q <= '0;
            strobe_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            ch_sr_q   <= ch_sr_d;
            bit_cnt_q <= bit_cnt_d;
            ch_q      <= ch_d;
            miss_q    <= miss_d;
            ch_data_q <= ch_data_d;
            strobe_q  <= strobe_d;
            err_q     <= err_d;
        end
    end

    // Truncating casts drop the oldest bit, giving a sliding window without a part-select.
    assign sr_shift = SYNC_LEN'({sr_q, din});
    assign word     = CH_W'({ch_sr_q, din});
    assign miss_inc = miss_q + MISS_W'(1);

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        ch_sr_d   = ch_sr_q;
        bit_cnt_d = bit_cnt_q;
        ch_d      = ch_q;
        miss_d    = miss_q;
        ch_data_d = ch_data_q;
        strobe_d  = '0;
        err_d     = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    sr_d = sr_shift;
                    if (sr_shift == SYNC_PAT) begin
                        state_d   = DATA;
                        ch_d      = '0;
                        bit_cnt_d = '0;
                        miss_d    = '0;
                    end
                end
                DATA: begin
                    ch_sr_d = word;
                    if (bit_cnt_q == CNT_W'(CH_W - 1)) begin
                        ch_data_d = word;
                        strobe_d  = 8'd1 << ch_q;
                        bit_cnt_d = '0;
                        ch_d      = ch_q + 3'd1;
                        if (ch_q == 3'd7) begin
                            state_d = CHECK;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                CHECK: begin
                    sr_d = sr_shift;
                    if (bit_cnt_q == CNT_W'(SYNC_LEN - 1)) begin
                        bit_cnt_d = '0;
                        ch_d      = '0;
                        if (sr_shift == SYNC_PAT) begin
                            miss_d  = '0;
                            state_d = DATA;
                        end else begin
                            err_d  = 1'b1;
                            miss_d = miss_inc;
                            if (miss_inc == MISS_W'(MISS_MAX)) begin
                                state_d = HUNT;
                                sr_d    = '0;
                            end else begin
                                state_d = DATA;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    sr_d    = '0;
                end
            endcase
        end
    end

    always_comb begin
        sel       = (state_q == DATA) ? ch_q : 3'd0;
        locked    = (state_q != HUNT);
        ch_data   = ch_data_q;
        ch_strobe = strobe_q;
        sync_err  = err_q;
    end

endmodule

// File: tb/tb_demux_1_8_tdm_ctrl.sv
// tb/tb_demux_1_8_tdm_ctrl.sv - scoreboard bench for demux_1_8_tdm_ctrl
module tb_demux_1_8_tdm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic [2:0] sel;
    logic [3:0] ch_data;
    logic [7:0] ch_strobe;
    logic       locked;
    logic       sync_err;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int err_seen = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        logic [7:0] strobe;
        logic [3:0] data;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    demux_1_8_tdm_ctrl #(
        .SYNC_LEN(8),
        .SYNC_PAT(8'hA5),
        .CH_W(4),
        .MISS_MAX(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(din_valid),
        .sel(sel),
        .ch_data(ch_data),
        .ch_strobe(ch_strobe),
        .locked(locked),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe seen must match the head of the scoreboard, including its cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sync_err === 1'b1) err_seen++;
            if (ch_strobe !== 8'h00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: strobe=%h data=%h cycle=%0d, required no strobe",
                             ch_strobe, ch_data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (ch_strobe !== mon_e.strobe || ch_data !== mon_e.data || cyc !== mon_e.at) begin
                        errors++;
                        $display("FAIL strobe_data: strobe=%h data=%h cycle=%0d, required strobe=%h data=%h cycle=%0d",
                                 ch_strobe, ch_data, cyc, mon_e.strobe, mon_e.data, mon_e.at);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap, input bit push, input int k, input logic [3:0] data);
        exp_t e;
        for (int g = 0; g < gap; g++) begin
            din_valid = 1'b0;
            din = 1'($urandom);
            tick();
        end
        din = b;
        din_valid = 1'b1;
        if (push) begin
            e.strobe = 8'd1 << k;
            e.data   = data;
            e.at     = cyc + 1;
            exp_q.push_back(e);
        end
        tick();
        din_valid = 1'b0;
    endtask

    task automatic send_sync(input logic [7:0] pat, input int gmax);
        for (int i = 7; i >= 0; i--) send_bit(pat[i], int'($urandom_range(0, gmax)), 1'b0, 0, 4'h0);
    endtask

    task automatic send_chan(input int k, input bit exp_on, input int gmax, input int nbits);
        logic [3:0] v;
        v = 4'(k + 1);
        for (int i = 3; i >= 4 - nbits; i--) begin
            if (exp_on) begin
                checks++;
                if (sel !== 3'(k)) begin
                    errors++;
                    $display("FAIL sel_ch%0d: sel=%0d, required %0d", k, sel, k);
                end
            end
            send_bit(v[i], int'($urandom_range(0, gmax)), exp_on && (i == 0), k, v);
        end
    endtask

    task automatic send_frame(input bit exp_on, input int gmax);
        for (int k = 0; k < 8; k++) send_chan(k, exp_on, gmax, 4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            din = 1'($urandom);
            din_valid = 1'($urandom);
            tick();
        end
        rst = 1'b0;
        din_valid = 1'b0;
        checks += 5;
        if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: sel=%0d, required 0", sel); end
        if (ch_data !== 4'h0) begin errors++; $display("FAIL reset_ch_data: ch_data=%h, required 0", ch_data); end
        if (ch_strobe !== 8'h00) begin errors++; $display("FAIL reset_strobe: ch_strobe=%h, required 00", ch_strobe); end
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: locked=%b, required 0", locked); end
        if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: sync_err=%b, required 0", sync_err); end
        mon_en = 1'b1;
    endtask

    task automatic lock_on_a5(input string name, input int gmax);
        logic [7:0] p;
        p = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(p[i], int'($urandom_range(0, gmax)), 1'b0, 0, 4'h0);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL %s_early_lock: locked=%b, required 0", name, locked); end
        send_bit(p[0], int'($urandom_range(0, gmax)), 1'b0, 0, 4'h0);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL %s_lock: locked=%b, required 1", name, locked); end
    endtask

    task automatic test_lock_route();
        int e0;
        e0 = err_seen;
        lock_on_a5("t2", 0);
        send_frame(1'b1, 0);
        send_sync(8'hA5, 0);
        tick();
        tick();
        checks += 3;
        if (locked !== 1'b1) begin errors++; $display("FAIL t2_hold_lock: locked=%b, required 1", locked); end
        if (err_seen !== e0) begin errors++; $display("FAIL t2_sync_err: pulses=%0d, required %0d", err_seen, e0); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL t2_drain: pending=%0d, required 0", exp_q.size()); end
    endtask

    task automatic test_gapped();
        int e0;
        e0 = err_seen;
        send_frame(1'b1, 3);
        send_sync(8'hA5, 3);
        tick();
        tick();
        checks += 3;
        if (locked !== 1'b1) begin errors++; $display("FAIL t3_hold_lock: locked=%b, required 1", locked); end
        if (err_seen !== e0) begin errors++; $display("FAIL t3_sync_err: pulses=%0d, required %0d", err_seen, e0); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL t3_drain: pending=%0d, required 0", exp_q.size()); end
    endtask

    task automatic test_flywheel();
        int e0;
        e0 = err_seen;
        send_frame(1'b1, 0);
        send_sync(8'hA4, 0);
        checks += 2;
        if (sync_err !== 1'b1) begin errors++; $display("FAIL t4_err_pulse1: sync_err=%b, required 1", sync_err); end
        if (locked !== 1'b1) begin errors++; $display("FAIL t4_flywheel_lock: locked=%b, required 1", locked); end
        send_frame(1'b1, 0);
        send_sync(8'hA5, 0);
        send_frame(1'b1, 0);
        send_sync(8'hA4, 0);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL t4_miss1_lock: locked=%b, required 1", locked); end
        send_frame(1'b1, 0);
        send_sync(8'hA4, 0);
        checks += 2;
        if (locked !== 1'b0) begin errors++; $display("FAIL t4_loss: locked=%b, required 0", locked); end
        if (sync_err !== 1'b1) begin errors++; $display("FAIL t4_err_pulse3: sync_err=%b, required 1", sync_err); end
        for (int i = 0; i < 40; i++) send_bit(1'b0, 0, 1'b0, 0, 4'h0);
        checks += 3;
        if (locked !== 1'b0) begin errors++; $display("FAIL t4_stay_unlocked: locked=%b, required 0", locked); end
        if (err_seen !== e0 + 3) begin errors++; $display("FAIL t4_err_count: pulses=%0d, required %0d", err_seen, e0 + 3); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL t4_drain: pending=%0d, required 0", exp_q.size()); end
    endtask

    task automatic test_false_lock();
        logic [7:0] w;
        logic [6:0] pre;
        logic       b;
        w = 8'h00;
        pre = 7'b1010010;
        for (int i = 0; i < 200; i++) begin
            b = ((i % 25) < 7) ? pre[6 - (i % 25)] : 1'($urandom);
            if ({w[6:0], b} == 8'hA5) b = ~b;
            w = {w[6:0], b};
            send_bit(b, int'($urandom_range(0, 1)), 1'b0, 0, 4'h0);
            checks++;
            if (locked !== 1'b0) begin errors++; $display("FAIL t5_noise_lock bit%0d: locked=%b, required 0", i, locked); end
        end
        for (int i = 0; i < 8; i++) send_bit(1'b0, 0, 1'b0, 0, 4'h0);
        lock_on_a5("t5", 0);
        send_frame(1'b1, 1);
        send_sync(8'hA5, 0);
        tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL t5_drain: pending=%0d, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) send_chan(k, 1'b1, 0, 4);
        send_chan(3, 1'b0, 0, 2);
        rst = 1'b1;
        din = 1'b1;
        din_valid = 1'b1;
        tick();
        rst = 1'b0;
        din_valid = 1'b0;
        checks += 5;
        if (locked !== 1'b0) begin errors++; $display("FAIL t6_locked: locked=%b, required 0", locked); end
        if (sel !== 3'd0) begin errors++; $display("FAIL t6_sel: sel=%0d, required 0", sel); end
        if (ch_strobe !== 8'h00) begin errors++; $display("FAIL t6_strobe: ch_strobe=%h, required 00", ch_strobe); end
        if (ch_data !== 4'h0) begin errors++; $display("FAIL t6_ch_data: ch_data=%h, required 0", ch_data); end
        if (sync_err !== 1'b0) begin errors++; $display("FAIL t6_sync_err: sync_err=%b, required 0", sync_err); end
        tick();
        lock_on_a5("t6", 0);
        send_frame(1'b1, 0);
        send_sync(8'hA5, 0);
        tick();
        tick();
        checks += 2;
        if (locked !== 1'b1) begin errors++; $display("FAIL t6_relock: locked=%b, required 1", locked); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL t6_drain: pending=%0d, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_lock_route();
        test_gapped();
        test_flywheel();
        test_false_lock();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
